csr_trap_ctrl: RTL

Sequencer in front of the machine-mode CSR file. It accepts CSR, ECALL and MRET requests from the execute stage, and gates timer interrupts between instructions. It drives the CSR file's one-hot control strobes over a two-cycle protocol and returns read data or a PC redirect to the fetch stage. It guarantees at most one CSR-file action per cycle, so the CSR file's OR-merged read port never sees overlapping selects.

---
 rtl/csr_pkg.sv | 38 +++
 rtl/csr_alu.sv | 42 ++++
 rtl/csr_trap_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR trap sequencer.
//   - CSR addresses of the machine-mode registers touched by the sequencer
//   - request opcode and CSR funct3 encodings
//   - trap cause constants
//   - sequencer state encoding
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        OP_CSR   = 2'd0,
        OP_ECALL = 2'd1,
        OP_MRET  = 2'd2,
        OP_NOP   = 2'd3
    } req_op_e;

    localparam logic [2:0] F3_CSRRW  = 3'd1;
    localparam logic [2:0] F3_CSRRS  = 3'd2;
    localparam logic [2:0] F3_CSRRC  = 3'd3;
    localparam logic [2:0] F3_CSRRWI = 3'd5;
    localparam logic [2:0] F3_CSRRSI = 3'd6;
    localparam logic [2:0] F3_CSRRCI = 3'd7;

    localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CSR_WR   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational read-modify-write merge for CSR instructions.
//   funct3   in  CSR variant (register and immediate forms)
//   old_val  in  value read from the CSR in the accept cycle
//   src      in  rs1 value or zero-extended uimm
//   wdata    out merged write value
//   we       out write enable; RS/RC with a zero source do not write
module csr_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] wdata,
    output logic            we
);

    always_comb begin
        wdata = old_val;
        we    = 1'b0;
        case (funct3)
            F3_CSRRW, F3_CSRRWI: begin
                wdata = src;
                we    = 1'b1;
            end
            F3_CSRRS, F3_CSRRSI: begin
                wdata = old_val | src;
                we    = |src;
            end
            F3_CSRRC, F3_CSRRCI: begin
                wdata = old_val & ~src;
                we    = |src;
            end
            default: begin
                wdata = old_val;
                we    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequencer between execute and the machine-mode CSR file.
//   req_*           in/out  request handshake from execute (CSR/ECALL/MRET/NOP)
//   resp_valid/rdata out    old CSR value, one cycle after a CSR/NOP accept
//   redirect_*      out     one-cycle fetch redirect after ECALL/MRET/interrupt
//   csr_id/re/we/wdata, ecall, mret, epc, tint_ena  out  CSR file strobes
//   csr_rdata, tint in      CSR file read data and timer-interrupt take
// At most one CSR-file action is driven per cycle; the interrupt take is only
// enabled in IDLE and beats a concurrent request.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned           XLEN        = 64,
    parameter logic [XLEN-1:0]       ECALL_CAUSE = XLEN'(CAUSE_ECALL_M)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr,
    input  logic [XLEN-1:0] req_src,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] next_pc,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [11:0]     csr_id,
    output logic            csr_re,
    output logic            csr_we,
    output logic            ecall,
    output logic            mret,
    output logic            tint_ena,
    output logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] epc,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            tint
);

    state_e            state_q, state_d;
    req_op_e           op_q, op_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [11:0]       csr_q, csr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   old_q, old_d;
    logic [XLEN-1:0]   target_q, target_d;

    logic [XLEN-1:0]   alu_wdata;
    logic              alu_we;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (funct3_q),
        .old_val (old_q),
        .src     (src_q),
        .wdata   (alu_wdata),
        .we      (alu_we)
    );

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        funct3_d       = funct3_q;
        csr_d          = csr_q;
        src_d          = src_q;
        old_d          = old_q;
        target_d       = target_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_id         = '0;
        csr_re         = 1'b0;
        csr_we         = 1'b0;
        ecall          = 1'b0;
        mret           = 1'b0;
        tint_ena       = 1'b0;
        csr_wdata      = '0;
        epc            = '0;

        // Every output is held low while reset is asserted; the flops are
        // cleared separately in the sequential block.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    tint_ena  = 1'b1;
                    req_ready = !tint;
                    if (tint) begin
                        epc      = next_pc;
                        target_d = csr_rdata;
                        state_d  = ST_REDIRECT;
                    end else if (req_valid) begin
                        op_d     = req_op_e'(req_op);
                        funct3_d = req_funct3;
                        csr_d    = req_csr;
                        src_d    = req_src;
                        unique case (req_op_e'(req_op))
                            OP_CSR: begin
                                csr_id  = req_csr;
                                csr_re  = 1'b1;
                                old_d   = csr_rdata;
                                state_d = ST_CSR_WR;
                            end
                            OP_ECALL: begin
                                ecall     = 1'b1;
                                epc       = req_pc;
                                csr_wdata = ECALL_CAUSE;
                                target_d  = csr_rdata;
                                state_d   = ST_REDIRECT;
                            end
                            OP_MRET: begin
                                mret     = 1'b1;
                                target_d = csr_rdata;
                                state_d  = ST_REDIRECT;
                            end
                            OP_NOP: begin
                                // Reuses the response cycle with a zero result
                                // and no CSR-file activity.
                                old_d   = '0;
                                state_d = ST_CSR_WR;
                            end
                        endcase
                    end
                end
                ST_CSR_WR: begin
                    resp_valid = 1'b1;
                    resp_rdata = old_q;
                    if (op_q == OP_CSR) begin
                        csr_we    = alu_we;
                        csr_wdata = alu_wdata;
                        csr_id    = alu_we ? csr_q : '0;
                    end
                    state_d = ST_IDLE;
                end
                ST_REDIRECT: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = target_q;
                    state_d        = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_CSR;
            funct3_q <= '0;
            csr_q    <= '0;
            src_q    <= '0;
            old_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            funct3_q <= funct3_d;
            csr_q    <= csr_d;
            src_q    <= src_d;
            old_q    <= old_d;
            target_q <= target_d;
        end
    end

endmodule
